// File: rtl/bram_pkg.sv
// Shared types and defaults for the BRAM port arbiter and related helpers.
package bram_pkg;

  localparam int BRAM_ADDR_W    = 32;
  localparam int BRAM_DATA_W    = 32;
  localparam int BRAM_N_REQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    HOLD = 2'b10
  } bram_arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_rr_pick.sv
// Combinational round-robin picker: first set bit of p searching upward
// from last+1, wrapping modulo N_REQ.
module bram_rr_pick
  import bram_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = rr_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] p,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan farthest-first so the candidate nearest after last overwrites the rest.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int   j;
      logic hit;
      j     = (int'(last) + k) % N_REQ;
      hit   = p[IDX_W'(j)];
      idx   = hit ? IDX_W'(j) : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between N_REQ masters, with a
// per-requester lock that keeps the grant across read-modify-write sequences.
module bram_port_arbiter
  import bram_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int ADDR_W = BRAM_ADDR_W,
  parameter  int DATA_W = BRAM_DATA_W,
  localparam int IDX_W  = rr_idx_w(N_REQ)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [N_REQ-1:0]         req_read,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_done,
  output logic [DATA_W-1:0]        req_rdata,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [DATA_W-1:0]        bram_wdata,
  output logic                     bram_read,
  output logic                     bram_write,
  input  logic                     bram_done,
  input  logic [DATA_W-1:0]        bram_rdata,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  output logic                     err
);

  bram_arb_state_t  state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pend_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_valid_s;
  logic             sel_rd_s;
  logic             sel_wr_s;
  logic             sel_lock_s;

  logic [ADDR_W-1:0] addr_s  [N_REQ];
  logic [DATA_W-1:0] wdata_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_s[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_s[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  assign pend_s     = req_read | req_write;
  assign sel_rd_s   = req_read[grant_q];
  assign sel_wr_s   = req_write[grant_q];
  assign sel_lock_s = req_lock[grant_q];

  bram_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .p     (pend_s),
    .last  (last_q),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Next-state selection, BRAM strobe muxing and completion routing.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    err_d      = err_q;
    bram_read  = 1'b0;
    bram_write = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    req_done   = '0;
    case (state_q)
      IDLE: begin
        if (bram_done) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (pick_valid_s) begin
          grant_d = pick_idx_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        bram_addr  = addr_s[grant_q];
        bram_wdata = wdata_s[grant_q];
        // A simultaneous read+write is resolved in favour of the write.
        bram_write = sel_wr_s;
        bram_read  = sel_rd_s & ~sel_wr_s;
        if (sel_rd_s && sel_wr_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (bram_done) begin
          req_done[grant_q] = 1'b1;
          last_d            = grant_q;
          if (sel_lock_s) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = BUSY;
        end
      end
      HOLD: begin
        if (bram_done) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (sel_rd_s || sel_wr_s) begin
          state_d = BUSY;
        end else if (!sel_lock_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, rotation pointer, grant and sticky error registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  assign req_rdata = bram_rdata;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requester agents,
// all outputs compared every cycle against a transaction-level reference.
module tb_bram_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               res;
  logic [NR-1:0]      req_read, req_write, req_lock, req_done;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [DW-1:0]      req_rdata, bram_wdata, bram_rdata;
  logic [AW-1:0]      bram_addr;
  logic               bram_read, bram_write, bram_done, busy, err;
  logic [IW-1:0]      grant_id;

  always #5 clk = ~clk;

  bram_port_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .res(res),
    .req_read(req_read), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_read(bram_read), .bram_write(bram_write),
    .bram_done(bram_done), .bram_rdata(bram_rdata),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: who owns the port, whether an access is open, whether parked.
  bit m_active, m_parked, m_err;
  int m_owner, m_last;
  logic [NR-1:0] last_done;

  task automatic model_reset();
    m_active = 1'b0; m_parked = 1'b0; m_err = 1'b0;
    m_owner = 0; m_last = NR - 1;
  endtask

  // Called just after a negedge with inputs driven; consumes one clock.
  task automatic step();
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [NR-1:0] e_done;
    bit n_act, n_park, n_err;
    int n_owner, n_last;
    #1;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_done = '0;
    if (m_active) begin
      e_wr    = req_write[m_owner];
      e_rd    = req_read[m_owner] && !req_write[m_owner];
      e_addr  = req_addr[m_owner*AW +: AW];
      e_wdata = req_wdata[m_owner*DW +: DW];
      if (bram_done) e_done[m_owner] = 1'b1;
    end
    chk("bram_read", 64'(bram_read), 64'(e_rd));
    chk("bram_write", 64'(bram_write), 64'(e_wr));
    chk("bram_addr", 64'(bram_addr), 64'(e_addr));
    chk("bram_wdata", 64'(bram_wdata), 64'(e_wdata));
    chk("req_done", 64'(req_done), 64'(e_done));
    chk("req_rdata", 64'(req_rdata), 64'(bram_rdata));
    last_done = e_done;
    n_act = m_active; n_park = m_parked; n_err = m_err;
    n_owner = m_owner; n_last = m_last;
    if (res) begin
      n_act = 1'b0; n_park = 1'b0; n_err = 1'b0; n_owner = 0; n_last = NR - 1;
    end else if (m_active) begin
      if (req_read[m_owner] && req_write[m_owner]) n_err = 1'b1;
      if (bram_done) begin
        n_act = 1'b0; n_last = m_owner; n_park = req_lock[m_owner];
      end
    end else if (m_parked) begin
      if (bram_done) n_err = 1'b1;
      if (req_read[m_owner] || req_write[m_owner]) begin
        n_act = 1'b1; n_park = 1'b0;
      end else if (!req_lock[m_owner]) begin
        n_park = 1'b0;
      end
    end else begin
      if (bram_done) n_err = 1'b1;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (!n_act && (req_read[c] || req_write[c])) begin
          n_act = 1'b1; n_owner = c;
        end
      end
    end
    @(posedge clk);
    #1;
    m_active = n_act; m_parked = n_park; m_err = n_err;
    m_owner = n_owner; m_last = n_last;
    chk("grant_id", 64'(grant_id), 64'(m_owner));
    chk("busy", 64'(busy), 64'(m_active | m_parked));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic clear_all();
    req_read = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; bram_done = 1'b0;
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr, input bit lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[i] = rd; req_write[i] = wr; req_lock[i] = lk;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_all();
    res = 1'b1;
    step();
    res = 1'b0;
  endtask

  int  rr_q[$];
  int  guard;
  bit  ag_on[NR];
  bit  ag_wr[NR];

  initial begin
    res = 1'b1;
    clear_all();
    bram_rdata = '0;
    last_done = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset with requests held, then first grant and strobe timing.
    @(negedge clk); req_read = 3'b011; step();
    chk("rst_busy", 64'(busy), 64'h0);
    @(negedge clk); res = 1'b0; step();
    chk("rst_first_grant", 64'(grant_id), 64'h0);
    @(negedge clk); #1 chk("rst_read_2nd", 64'(bram_read), 64'h1);
    bram_done = 1'b1; step();
    @(negedge clk); bram_done = 1'b0; req_read[0] = 1'b0; step();
    @(negedge clk); bram_done = 1'b1; step();
    @(negedge clk); clear_all(); step();

    // Single read from requester 1.
    do_reset();
    @(negedge clk); set_req(1, 1'b1, 1'b0, 1'b0, 16'h0040, 32'h0); step();
    repeat (2) begin @(negedge clk); step(); end
    @(negedge clk); bram_done = 1'b1; bram_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_addr", 64'(bram_addr), 64'h40);
    chk("rd_done", 64'(req_done), 64'h2);
    chk("rd_rdata", 64'(req_rdata), 64'hDEADBEEF);
    step();
    chk("rd_grant", 64'(grant_id), 64'h1);
    @(negedge clk); clear_all(); step();

    // Round-robin fairness with continuous requests and 1-cycle done.
    do_reset();
    @(negedge clk); req_read = 3'b111; step();
    guard = 0;
    while (rr_q.size() < 6 && guard < 40) begin
      @(negedge clk);
      bram_done = m_active;
      #1;
      if (m_active) rr_q.push_back(int'(grant_id));
      step();
      guard++;
    end
    chk("rr_count", 64'(rr_q.size()), 64'd6);
    for (int k = 0; k < rr_q.size(); k++)
      chk($sformatf("rr_grant%0d", k), 64'(rr_q[k]), 64'(k % NR));
    @(negedge clk); clear_all(); step();

    // Locked read-modify-write by requester 0 while requester 1 waits.
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0);
    step();
    @(negedge clk); #1 chk("rmw_rd_addr", 64'(bram_addr), 64'h10);
    bram_done = 1'b1; step();
    @(negedge clk); bram_done = 1'b0; set_req(0, 1'b0, 1'b0, 1'b1, 16'h0010, 32'h0); step();
    @(negedge clk); set_req(0, 1'b0, 1'b1, 1'b1, 16'h0010, 32'h12345678);
    #1 chk("rmw_hold_quiet", 64'({bram_read, bram_write}), 64'h0);
    step();
    @(negedge clk); #1 chk("rmw_write", 64'(bram_write), 64'h1);
    chk("rmw_wr_addr", 64'(bram_addr), 64'h10);
    bram_done = 1'b1; step();
    @(negedge clk); bram_done = 1'b0; set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0); step();
    @(negedge clk); step();
    chk("rmw_grant1", 64'(grant_id), 64'h1);
    @(negedge clk); #1 chk("rmw_r1_addr", 64'(bram_addr), 64'h20);
    bram_done = 1'b1; step();
    @(negedge clk); clear_all(); step();

    // Read+write collision, then spurious done in IDLE.
    do_reset();
    @(negedge clk); set_req(2, 1'b1, 1'b1, 1'b0, 16'h0030, 32'hA5A5A5A5); step();
    @(negedge clk); #1 chk("err_rw_read", 64'(bram_read), 64'h0);
    chk("err_rw_write", 64'(bram_write), 64'h1);
    step();
    chk("err_rw_flag", 64'(err), 64'h1);
    @(negedge clk); bram_done = 1'b1; step();
    @(negedge clk); clear_all(); step();
    do_reset();
    chk("err_cleared", 64'(err), 64'h0);
    @(negedge clk); bram_done = 1'b1; step();
    chk("err_spurious", 64'(err), 64'h1);
    chk("err_spur_idle", 64'(busy), 64'h0);
    repeat (3) begin @(negedge clk); clear_all(); step(); end
    chk("err_sticky", 64'(err), 64'h1);

    // Reset in the middle of a locked access.
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b1, 16'h0050, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0060, 32'h0);
    step();
    chk("mid_busy", 64'(busy), 64'h1);
    @(negedge clk); res = 1'b1; step();
    chk("mid_rst_busy", 64'(busy), 64'h0);
    @(negedge clk); res = 1'b0;
    #1 chk("mid_rst_strobe", 64'({bram_read, bram_write}), 64'h0);
    step();
    chk("mid_rst_last", 64'(grant_id), 64'h0);
    @(negedge clk); clear_all(); step();

    // Randomized agents: hold until done, random locks, rare violations.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (last_done[i]) begin
          ag_on[i] = 1'b0;
          if ($urandom_range(0, 1) == 0) req_lock[i] = 1'b0;
        end else if (!ag_on[i] && $urandom_range(0, 3) == 0) begin
          ag_on[i] = 1'b1;
          ag_wr[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = AW'($urandom);
          req_wdata[i*DW +: DW] = $urandom;
          req_lock[i] = ($urandom_range(0, 3) == 0);
        end else if (!ag_on[i] && $urandom_range(0, 7) == 0) begin
          req_lock[i] = 1'b0;
        end
        req_read[i]  = ag_on[i] && (!ag_wr[i] || $urandom_range(0, 99) == 0);
        req_write[i] = ag_on[i] && ag_wr[i];
      end
      bram_rdata = $urandom;
      if (m_active && (req_read[m_owner] || req_write[m_owner]))
        bram_done = ($urandom_range(0, 2) == 0);
      else
        bram_done = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
